// File: rtl/qd1_audio_pkg.sv
// Shared audio types and constants for the codec DAC streaming path.
package qd1_audio_pkg;

    localparam int unsigned SAMPLE_W = 16;

    // DACLRCK level that marks the left channel slot in I2S framing
    localparam logic LRCK_LEFT = 1'b0;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_frame_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous stereo-frame FIFO; pointers carry an extra wrap bit so full/empty are unambiguous.
module audio_sample_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata_c,
    output logic                       o_full_c,
    output logic                       o_empty_c,
    output logic [$clog2(DEPTH):0]     o_level_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_level_c = r_wr_ptr - r_rd_ptr;
    assign o_full_c  = (o_level_c == LVL_FULL);
    assign o_empty_c = (r_wr_ptr == r_rd_ptr);
    assign o_rdata_c = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push & ~o_full_c;
    assign w_do_pop  = i_pop & ~o_empty_c;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: pointers define what is valid
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/i2s_dac_stream.sv
// Buffers stereo PCM frames and serialises them onto the codec DAC line in I2S format,
// oversampling the codec-mastered BCLK/DACLRCK in the system clock domain.
module i2s_dac_stream
    import qd1_audio_pkg::*;
#(
    parameter int unsigned DATA_W      = SAMPLE_W,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                          clk_50_clk,
    input  logic                          reset_reset_n,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_left,
    input  logic [DATA_W-1:0]             in_right,
    input  logic                          audio_out_BCLK,
    input  logic                          audio_out_DACLRCK,
    output logic                          audio_out_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic [CNT_W-1:0]              underrun_count,
    input  logic                          clear_count
);

    localparam int unsigned FRAME_W = 2 * DATA_W;
    localparam int unsigned BCNT_W  = $clog2(DATA_W);

    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrck_sync;
    logic                   r_bclk_d;
    logic                   r_lrck_q;
    logic                   r_lrck_qq;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_hold;
    logic [BCNT_W-1:0]      r_bits_left;
    logic                   r_dacdat;
    logic                   r_underrun;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_bclk_s;
    logic                   w_bclk_rise;
    logic                   w_bclk_fall;
    logic                   w_word_start;
    logic                   w_left_start;
    logic                   w_pop;
    logic                   w_underrun_ev;
    logic                   w_full;
    logic                   w_empty;
    logic [FRAME_W-1:0]     w_rdata;
    logic [DATA_W-1:0]      w_load_word;

    audio_sample_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk_50_clk),
        .i_rst_n   (reset_reset_n),
        .i_push    (in_valid),
        .i_wdata   ({in_left, in_right}),
        .i_pop     (w_pop),
        .o_rdata_c (w_rdata),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_level_c (fifo_level)
    );

    assign in_ready         = ~w_full;
    assign audio_out_DACDAT = r_dacdat;
    assign underrun         = r_underrun;
    assign underrun_count   = r_cnt;

    assign w_bclk_s      = r_bclk_sync[SYNC_STAGES-1];
    assign w_bclk_rise   = w_bclk_s & ~r_bclk_d;
    assign w_bclk_fall   = ~w_bclk_s & r_bclk_d;
    // LRCK captured on rises lags one bit, giving the I2S one-bit delay for free
    assign w_word_start  = w_bclk_fall & (r_lrck_q != r_lrck_qq);
    assign w_left_start  = w_word_start & (r_lrck_q == LRCK_LEFT);
    assign w_pop         = w_left_start & enable & ~w_empty;
    assign w_underrun_ev = w_left_start & enable & w_empty;

    always_comb begin
        w_load_word = '0;
        if (enable) begin
            if (r_lrck_q == LRCK_LEFT) begin
                if (!w_empty) w_load_word = w_rdata[FRAME_W-1 -: DATA_W];
            end else begin
                w_load_word = r_hold;
            end
        end
    end

    always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_bclk_d    <= 1'b0;
            r_lrck_q    <= LRCK_LEFT;
            r_lrck_qq   <= LRCK_LEFT;
        end else begin
            r_bclk_sync <= (r_bclk_sync << 1) | SYNC_STAGES'(audio_out_BCLK);
            r_lrck_sync <= (r_lrck_sync << 1) | SYNC_STAGES'(audio_out_DACLRCK);
            r_bclk_d    <= w_bclk_s;
            if (w_bclk_rise) begin
                r_lrck_q  <= r_lrck_sync[SYNC_STAGES-1];
                r_lrck_qq <= r_lrck_q;
            end
        end
    end

    // Serialiser: data only moves on BCLK fall strobes, MSB first, zero-filled tail
    always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_shift     <= '0;
            r_hold      <= '0;
            r_bits_left <= '0;
            r_dacdat    <= 1'b0;
        end else if (w_bclk_fall) begin
            if (w_word_start) begin
                r_shift     <= w_load_word;
                r_dacdat    <= w_load_word[DATA_W-1];
                r_bits_left <= BCNT_W'(DATA_W - 1);
                if (w_left_start) r_hold <= w_pop ? w_rdata[DATA_W-1:0] : '0;
            end else if (r_bits_left != '0) begin
                r_shift     <= r_shift << 1;
                r_dacdat    <= r_shift[DATA_W-2];
                r_bits_left <= r_bits_left - BCNT_W'(1);
            end else begin
                r_dacdat    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_underrun <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_underrun <= w_underrun_ev;
            if (clear_count) begin
                r_cnt <= '0;
            end else if (w_underrun_ev && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_stream.sv
// Bench: codec BFM drives BCLK/LRCK, a queue model predicts every DAC bit, level and underrun count.
`timescale 1ns/1ps
module tb_i2s_dac_stream;
    import qd1_audio_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SLOT  = 32;
    localparam int unsigned HALF  = 162;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        bclk;
    logic        lrck;
    logic        dacdat;
    logic [3:0]  level;
    logic        underrun;
    logic [15:0] ucount;
    logic        clear_count;

    logic        in_ready2;
    logic        dacdat2;
    logic [3:0]  level2;
    logic        underrun2;
    logic [1:0]  ucount2;

    stereo_frame_t mq[$];
    logic [15:0]   m_hold;
    logic [15:0]   cap;
    int            m_cnt;
    int            m_pulses;
    int            pulses;
    bit            prev_lrck;
    int            total;
    int            bad;

    always #10 clk = ~clk;

    i2s_dac_stream dut (
        .clk_50_clk        (clk),
        .reset_reset_n     (rst_n),
        .enable            (enable),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_left           (in_left),
        .in_right          (in_right),
        .audio_out_BCLK    (bclk),
        .audio_out_DACLRCK (lrck),
        .audio_out_DACDAT  (dacdat),
        .fifo_level        (level),
        .underrun          (underrun),
        .underrun_count    (ucount),
        .clear_count       (clear_count)
    );

    // Narrow counter instance to reach saturation within a short run
    i2s_dac_stream #(.CNT_W(2)) dut_sat (
        .clk_50_clk        (clk),
        .reset_reset_n     (rst_n),
        .enable            (enable),
        .in_valid          (in_valid),
        .in_ready          (in_ready2),
        .in_left           (in_left),
        .in_right          (in_right),
        .audio_out_BCLK    (bclk),
        .audio_out_DACLRCK (lrck),
        .audio_out_DACDAT  (dacdat2),
        .fifo_level        (level2),
        .underrun          (underrun2),
        .underrun_count    (ucount2),
        .clear_count       (clear_count)
    );

    always @(negedge clk) if (underrun === 1'b1) pulses++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        bit acc;
        @(negedge clk);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        #1;
        acc = (mq.size() < DEPTH);
        chk("push_ready", 32'(in_ready), 32'(acc));
        @(posedge clk);
        if (acc) mq.push_back('{left: l, right: r});
        #1 in_valid = 1'b0;
    endtask

    // One codec slot; action: 1 drop enable, 2 reset mid-word, 3 raise enable
    task automatic run_slot(input bit ch, input int action);
        logic [15:0]   word;
        logic          exp_bit;
        bit            started;
        stereo_frame_t f;
        word      = '0;
        started   = (ch != prev_lrck);
        prev_lrck = ch;
        cap       = '0;
        for (int b = 0; b < SLOT; b++) begin
            bclk = 1'b0;
            if (b == 0) lrck = ch;
            if (b == 1 && started) begin
                if (ch == 1'b0) begin
                    m_hold = '0;
                    if (!enable) begin
                        word = '0;
                    end else if (mq.size() == 0) begin
                        word = '0;
                        m_pulses++;
                        if (m_cnt < 65535) m_cnt++;
                    end else begin
                        f      = mq.pop_front();
                        word   = f.left;
                        m_hold = f.right;
                    end
                end else begin
                    word = enable ? m_hold : 16'h0000;
                end
            end
            #HALF;
            bclk    = 1'b1;
            exp_bit = (b >= 1 && b <= 16) ? word[16-b] : 1'b0;
            chk($sformatf("dacdat ch%0d bit%0d", ch, b), 32'(dacdat), 32'(exp_bit));
            if (b >= 1 && b <= 16) cap = {cap[14:0], dacdat};
            if (b == 8 && action == 1) enable = 1'b0;
            if (b == 8 && action == 3) enable = 1'b1;
            if (b == 10 && action == 2) rst_n = 1'b1;
            if (b == 28) begin
                chk("level", 32'(level), 32'(mq.size()));
                chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
                chk("ucount", 32'(ucount), 32'(m_cnt));
                chk("ucount_sat", 32'(ucount2), 32'((m_cnt > 3) ? 3 : m_cnt));
                chk("pulses", 32'(pulses), 32'(m_pulses));
            end
            if (b == 8 && action == 2) begin
                rst_n = 1'b0;
                #1;
                chk("rst_dacdat", 32'(dacdat), 32'd0);
                chk("rst_level", 32'(level), 32'd0);
                mq.delete();
                m_hold = '0;
                m_cnt  = 0;
                word   = '0;
                #(HALF - 1);
            end else begin
                #HALF;
            end
        end
    endtask

    task automatic frames(input int n, input int max_push);
        for (int k = 0; k < n; k++) begin
            run_slot(1'b0, 0);
            run_slot(1'b1, 0);
            repeat ($urandom_range(0, max_push)) push_frame(16'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        bit acc;
        total = 0; bad = 0; pulses = 0; m_pulses = 0; m_cnt = 0;
        m_hold = '0; prev_lrck = 1'b0; cap = '0;
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
        bclk = 1'b0; lrck = 1'b0; clear_count = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hold_level", 32'(level), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dacdat", 32'(dacdat), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_count", 32'(ucount), 32'd0);
        enable = 1'b1;

        // Fill with no LRCK activity: 8 accepted, then in_ready stays low
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_left  = (i == 0) ? 16'hA55A : 16'($urandom);
            in_right = (i == 0) ? 16'h0F0F : 16'($urandom);
            #1;
            acc = (mq.size() < DEPTH);
            chk("fill_ready", 32'(in_ready), 32'(acc));
            @(posedge clk);
            if (acc) mq.push_back('{left: in_left, right: in_right});
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("fill_level", 32'(level), 32'd8);
        chk("fill_ready_low", 32'(in_ready), 32'd0);
        chk("fill_dacdat", 32'(dacdat), 32'd0);

        run_slot(1'b1, 0);
        run_slot(1'b0, 0);
        chk("t1_left", 32'(cap), 32'h0000A55A);
        chk("t2_level_after_pop", 32'(level), 32'd7);
        chk("t2_ready_after_pop", 32'(in_ready), 32'd1);
        run_slot(1'b1, 0);
        chk("t1_right", 32'(cap), 32'h00000F0F);

        // Drain 7 more frames then 3 underruns
        frames(10, 0);
        chk("t3_count", 32'(ucount), 32'd3);
        chk("t3_pulses", 32'(pulses), 32'd3);
        @(negedge clk) clear_count = 1'b1;
        @(negedge clk) clear_count = 1'b0;
        m_cnt = 0;
        chk("t3_cleared", 32'(ucount), 32'd0);
        chk("t3_cleared_sat", 32'(ucount2), 32'd0);

        frames(5, 0);
        chk("t4_count", 32'(ucount), 32'd5);
        chk("t4_saturated", 32'(ucount2), 32'd3);

        frames(12, 2);

        // Enable drop mid right word, then idle frames with pushes
        run_slot(1'b0, 0);
        run_slot(1'b1, 1);
        push_frame(16'($urandom), 16'($urandom));
        frames(2, 1);
        run_slot(1'b0, 0);
        run_slot(1'b1, 3);
        push_frame(16'($urandom), 16'($urandom));
        push_frame(16'($urandom), 16'($urandom));
        frames(1, 0);

        // Reset mid left word, then first data at the following left start
        run_slot(1'b0, 2);
        run_slot(1'b1, 0);
        push_frame(16'h1234, 16'hFEDC);
        run_slot(1'b0, 0);
        chk("t5_left", 32'(cap), 32'h00001234);
        run_slot(1'b1, 0);
        chk("t5_right", 32'(cap), 32'h0000FEDC);
        frames(2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
